// File: rtl/matrix_result_reader.sv
// Unloads result matrix C from memory in row-major order onto a valid/ready stream.
// Optional: define READER_CHECKSUM_EN to add a 16-bit running checksum output.
module matrix_result_reader #(
    parameter int ROW       = 3,
    parameter int COLUMN    = 3,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0,
    localparam int RW = (ROW > 1) ? $clog2(ROW) : 1,
    localparam int CW = (COLUMN > 1) ? $clog2(COLUMN) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              complete,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_read_address,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [RW-1:0]     out_row,
    output logic [CW-1:0]     out_col,
    output logic              out_last,
    output logic              busy,
    output logic              done
`ifdef READER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [RW-1:0] ROW_MAX = RW'(ROW - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLUMN - 1);

    state_t              state_r, state_s;
    logic [RW-1:0]       row_r, row_s;
    logic [CW-1:0]       col_r, col_s;
    logic                mem_read_s;
    logic [ADDR_W-1:0]   addr_s;
    logic                out_valid_s;
    logic [DATA_W-1:0]   out_data_s;
    logic [RW-1:0]       out_row_s;
    logic [CW-1:0]       out_col_s;
    logic                out_last_s;
    logic                busy_s;
    logic                done_s;

    // Address arithmetic wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [RW-1:0] r, input logic [CW-1:0] c);
        return ADDR_W'(BASE_ADDR) + ADDR_W'(r) * ADDR_W'(COLUMN) + ADDR_W'(c);
    endfunction

    // Next-state and next-output computation; every output is registered from these.
    always_comb begin
        state_s     = state_r;
        row_s       = row_r;
        col_s       = col_r;
        mem_read_s  = 1'b0;
        addr_s      = mem_read_address;
        out_valid_s = out_valid;
        out_data_s  = out_data;
        out_row_s   = out_row;
        out_col_s   = out_col;
        out_last_s  = out_last;
        case (state_r)
            IDLE: begin
                if (complete) begin
                    state_s    = REQ;
                    row_s      = {RW{1'b0}};
                    col_s      = {CW{1'b0}};
                    mem_read_s = 1'b1;
                    addr_s     = addr_of({RW{1'b0}}, {CW{1'b0}});
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                state_s = WAIT;
            end
            WAIT: begin
                out_data_s  = mem_data;
                out_valid_s = 1'b1;
                out_row_s   = row_r;
                out_col_s   = col_r;
                out_last_s  = (row_r == ROW_MAX) && (col_r == COL_MAX);
                state_s     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_s = 1'b0;
                    if (out_last) begin
                        state_s = DONE;
                    end else begin
                        if (col_r == COL_MAX) begin
                            col_s = {CW{1'b0}};
                            row_s = row_r + 1'b1;
                        end else begin
                            col_s = col_r + 1'b1;
                        end
                        state_s    = REQ;
                        mem_read_s = 1'b1;
                        addr_s     = addr_of(row_s, col_s);
                    end
                end else begin
                    state_s = HOLD;
                end
            end
            DONE: begin
                if (!complete) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s == REQ) || (state_s == WAIT) || (state_s == HOLD);
        done_s = (state_s == DONE);
    end

    // State, indices and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r          <= IDLE;
            row_r            <= {RW{1'b0}};
            col_r            <= {CW{1'b0}};
            mem_read         <= 1'b0;
            mem_read_address <= {ADDR_W{1'b0}};
            out_valid        <= 1'b0;
            out_data         <= {DATA_W{1'b0}};
            out_row          <= {RW{1'b0}};
            out_col          <= {CW{1'b0}};
            out_last         <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            state_r          <= state_s;
            row_r            <= row_s;
            col_r            <= col_s;
            mem_read         <= mem_read_s;
            mem_read_address <= addr_s;
            out_valid        <= out_valid_s;
            out_data         <= out_data_s;
            out_row          <= out_row_s;
            out_col          <= out_col_s;
            out_last         <= out_last_s;
            busy             <= busy_s;
            done             <= done_s;
        end
    end

`ifdef READER_CHECKSUM_EN
    // Running sum of accepted elements, restarted when a new unload begins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum <= 16'd0;
        end else if (state_r == IDLE && complete) begin
            checksum <= 16'd0;
        end else if (state_r == HOLD && out_ready) begin
            checksum <= checksum + 16'(out_data);
        end else begin
            checksum <= checksum;
        end
    end
`endif

endmodule

// File: tb/tb_matrix_result_reader.sv
// Scoreboard bench for matrix_result_reader: expected elements/addresses are queued by
// the stimulus, a negedge monitor pops and compares on each read strobe and handshake.
module tb_matrix_result_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       complete = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] mem_data = 8'd0;
    logic       mem_read;
    logic [5:0] mem_read_address;
    logic       out_valid;
    logic [7:0] out_data;
    logic [1:0] out_row;
    logic [1:0] out_col;
    logic       out_last;
    logic       busy;
    logic       done;
`ifdef READER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    matrix_result_reader dut (
        .clk(clk), .rst_n(rst_n), .complete(complete),
        .mem_read(mem_read), .mem_read_address(mem_read_address), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .out_last(out_last),
        .busy(busy), .done(done)
`ifdef READER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] r;
        logic [1:0] c;
        logic       l;
    } elem_t;

    elem_t      exp_q[$];
    logic [5:0] addr_q[$];
    logic [7:0] mem[64];
    int         total = 0;
    int         bad = 0;
    int         nreads = 0;
    int         lat;
    int         r0;
    elem_t      mon_e;
    logic [5:0] mon_a;

    // One-cycle-latency result memory: C = 1..9 row-major at address 0.
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = (i < 9) ? 8'(i + 1) : 8'hEE;
    end

    always @(posedge clk) begin
        if (mem_read) mem_data <= mem[mem_read_address];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_all();
        elem_t e;
        for (int i = 0; i < 9; i++) begin
            e.d = 8'(i + 1);
            e.r = 2'(i / 3);
            e.c = 2'(i % 3);
            e.l = (i == 8);
            exp_q.push_back(e);
            addr_q.push_back(6'(i));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_read"}, 32'(mem_read), 32'd0);
        chk({tag, "_addr"}, 32'(mem_read_address), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
        chk({tag, "_out_row"}, 32'(out_row), 32'd0);
        chk({tag, "_out_col"}, 32'(out_col), 32'd0);
        chk({tag, "_out_last"}, 32'(out_last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 200 && !done; k++) step();
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_read(input logic [5:0] a, input string tag);
        for (int k = 0; k < 200 && !(mem_read && mem_read_address == a); k++) step();
        chk({tag, "_seen"}, 32'(mem_read && mem_read_address == a), 32'd1);
    endtask

    // Monitor: checks every read strobe and every accepted element against the queues.
    always @(negedge clk) begin
        if (rst_n && mem_read) begin
            nreads++;
            if (addr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_read: got addr %0d expected none", mem_read_address);
            end else begin
                mon_a = addr_q.pop_front();
                chk("read_addr", 32'(mem_read_address), 32'(mon_a));
            end
        end
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_elem: got data %0d expected none", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("elem{data,row,col,last}", 32'({out_data, out_row, out_col, out_last}), 32'(mon_e));
            end
        end
    end

    initial begin
        step();
        step();
        chk_zero("reset");
        rst_n = 1'b1;

        // Plain unload with sink always ready, plus first-valid latency.
        push_all();
        out_ready = 1'b1;
        complete = 1'b1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'd3);
        wait_done("run1");

        // Holding complete high must not restart; dropping it returns to IDLE.
        r0 = nreads;
        repeat (10) step();
        chk("no_rerun_reads", 32'(nreads), 32'(r0));
        chk("no_rerun_done", 32'(done), 32'd1);
        complete = 1'b0;
        step();
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Second unload with a backpressure stall on element 5.
        push_all();
        complete = 1'b1;
        wait_read(6'd4, "read4");
        out_ready = 1'b0;
        step();
        step();
        r0 = nreads;
        for (int k = 0; k < 4; k++) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_payload", 32'({out_data, out_row, out_col, out_last}), 32'({8'd5, 2'd1, 2'd1, 1'b0}));
            step();
        end
        chk("stall_no_read", 32'(nreads), 32'(r0));
        out_ready = 1'b1;
        wait_done("run2");
`ifdef READER_CHECKSUM_EN
        chk("checksum", 32'(checksum), 32'd45);
`endif
        complete = 1'b0;
        step();

        // Reset while holding element 4, then restart from (0,0).
        push_all();
        complete = 1'b1;
        wait_read(6'd3, "read3");
        out_ready = 1'b0;
        step();
        step();
        chk("hold4_payload", 32'({out_valid, out_data}), 32'({1'b1, 8'd4}));
        rst_n = 1'b0;
        step();
        chk_zero("midreset");
        rst_n = 1'b1;
        exp_q.delete();
        addr_q.delete();
        push_all();
        out_ready = 1'b1;
        wait_done("run3");
        complete = 1'b0;
        step();
        step();

        // complete dropped during element 2: unload still finishes, then back to IDLE.
        push_all();
        complete = 1'b1;
        wait_read(6'd1, "read1");
        complete = 1'b0;
        wait_done("run4");
        step();
        chk("drop_idle_done", 32'(done), 32'd0);
        chk("drop_idle_busy", 32'(busy), 32'd0);

        repeat (3) step();
        chk("addr_queue_empty", 32'(addr_q.size()), 32'd0);
        chk("elem_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
